// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS-subset control FSM: sequences fetch/decode/execute/memory/write-back,
// waits on a memory-ready handshake, and tracks halt, fault and retired instructions.
module multicycle_controller #(
  parameter int ALU_OP_W    = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         instruction,
  input  logic                mem_ready,
  input  logic                alu_zero,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic [1:0]          pc_src,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_reg,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                halted,
  output logic                fault,
  output logic [CNT_W-1:0]    retired,
  output logic [3:0]          state
);

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_MEMADDR = 4'd2,
    ST_MEMRD   = 4'd3,
    ST_MEMWB   = 4'd4,
    ST_MEMWR   = 4'd5,
    ST_EXEC    = 4'd6,
    ST_RWB     = 4'd7,
    ST_BRANCH  = 4'd8,
    ST_JUMP    = 4'd9,
    ST_IEXEC   = 4'd10,
    ST_IWB     = 4'd11,
    ST_HALT    = 4'd12,
    ST_FAULT   = 4'd13
  } state_t;

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t            state_q, state_nx;
  logic [WAIT_W-1:0] wait_cnt;
  logic [2:0]        op3;
  logic              retire;
  logic              timed_out;
  logic [5:0]        opcode, funct;
  logic              unused_ok;

  assign opcode    = instruction[31:26];
  assign funct     = instruction[5:0];
  assign unused_ok = ^{instruction[25:6], alu_zero};
  assign state     = state_q;
  assign alu_op    = ALU_OP_W'(op3);

  // The cycle whose increment would reach the limit is the last one allowed.
  assign timed_out = (MEM_TIMEOUT > 0) && !mem_ready && (wait_cnt == WAIT_LAST);

  always_comb begin
    state_nx      = state_q;
    retire        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 2'd0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_reg       = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    op3           = 3'd0;
    case (state_q)
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_nx = ST_DECODE;
        end else if (timed_out) begin
          state_nx = ST_FAULT;
        end
      end
      ST_DECODE: begin
        alu_src_b = 2'd3;
        case (opcode)
          6'h00:        state_nx = ST_EXEC;
          6'h23, 6'h2b: state_nx = ST_MEMADDR;
          6'h04:        state_nx = ST_BRANCH;
          6'h08:        state_nx = ST_IEXEC;
          6'h02:        state_nx = ST_JUMP;
          6'h3f: begin
            state_nx = ST_HALT;
            retire   = 1'b1;
          end
          default:      state_nx = ST_FAULT;
        endcase
      end
      ST_EXEC: begin
        alu_src_a = 1'b1;
        state_nx  = ST_RWB;
        case (funct)
          6'h20:   op3 = 3'd0;
          6'h22:   op3 = 3'd6;
          6'h24:   op3 = 3'd1;
          6'h25:   op3 = 3'd2;
          6'h2a:   op3 = 3'd4;
          default: state_nx = ST_FAULT;
        endcase
      end
      ST_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
        state_nx  = ST_FETCH;
      end
      ST_MEMADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_nx  = (opcode == 6'h2b) ? ST_MEMWR : ST_MEMRD;
      end
      ST_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready)      state_nx = ST_MEMWB;
        else if (timed_out) state_nx = ST_FAULT;
      end
      ST_MEMWB: begin
        reg_write = 1'b1;
        mem_reg   = 1'b1;
        retire    = 1'b1;
        state_nx  = ST_FETCH;
      end
      ST_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          retire   = 1'b1;
          state_nx = ST_FETCH;
        end else if (timed_out) begin
          state_nx = ST_FAULT;
        end
      end
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        op3           = 3'd6;
        pc_write_cond = 1'b1;
        pc_src        = 2'd1;
        retire        = 1'b1;
        state_nx      = ST_FETCH;
      end
      ST_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'd2;
        retire   = 1'b1;
        state_nx = ST_FETCH;
      end
      ST_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_nx  = ST_IWB;
      end
      ST_IWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_nx  = ST_FETCH;
      end
      ST_HALT, ST_FAULT: state_nx = state_q;
      default:           state_nx = ST_FAULT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      wait_cnt <= '0;
      retired  <= '0;
      halted   <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state_q <= state_nx;
      if (state_nx != state_q)
        wait_cnt <= '0;
      else if (!mem_ready)
        wait_cnt <= wait_cnt + 1'b1;
      if (retire)
        retired <= retired + 1'b1;
      halted <= halted | (state_nx == ST_HALT);
      fault  <= fault  | (state_nx == ST_FAULT);
    end
  end

endmodule
